// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode map, opcode count and sequencer state encoding
package alu_pkg;

  localparam int NUM_OPS = 13;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NAND = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_XNOR = 4'd10;
  localparam logic [3:0] OP_INV  = 4'd11;
  localparam logic [3:0] OP_NEG  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - zero and negative flags derived from the captured result
module alu_flag_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] i_data,
  output logic              o_zero,
  output logic              o_neg
);

  assign o_zero = (i_data == '0);
  assign o_neg  = i_data[DATA_W-1];

endmodule

// File: rtl/alu_op_seq.sv
// rtl/alu_op_seq.sv - request sequencer driving an external result mux and holding its result
module alu_op_seq #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_opcode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_chain,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [OP_W-1:0]   sel,
  output logic              enable,
  input  logic [DATA_W-1:0] mux_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zero,
  output logic              res_neg,
  output logic              res_err,
  output logic [7:0]        op_count
);

  import alu_pkg::*;

  alu_state_e        r_state;
  logic [OP_W-1:0]   r_sel;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_enable;
  logic              r_res_valid;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_err;
  logic [DATA_W-1:0] r_last_res;
  logic [7:0]        r_op_count;
  logic              w_legal;

  assign w_legal = (32'(in_opcode) < 32'(NUM_OPS));

  // Illegal opcodes skip ISSUE entirely so the mux is never enabled for them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_enable    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_last_res  <= '0;
      r_op_count  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_sel      <= in_opcode;
            r_op_b     <= in_b;
            r_op_a     <= in_chain ? r_last_res : in_a;
            r_op_count <= r_op_count + 8'd1;
            if (w_legal) begin
              r_enable <= 1'b1;
              r_state  <= ST_ISSUE;
            end else begin
              r_res_data  <= '0;
              r_res_err   <= 1'b1;
              r_res_valid <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
        end
        ST_ISSUE: begin
          r_enable    <= 1'b0;
          r_res_data  <= mux_out;
          r_res_err   <= 1'b0;
          r_last_res  <= mux_out;
          r_res_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_enable    <= 1'b0;
          r_res_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign sel       = r_sel;
  assign enable    = r_enable;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign op_count  = r_op_count;

  alu_flag_gen #(
    .DATA_W (DATA_W)
  ) u_flag_gen (
    .i_data (r_res_data),
    .o_zero (res_zero),
    .o_neg  (res_neg)
  );

endmodule

// File: tb/tb_alu_op_seq.sv
// tb/tb_alu_op_seq.sv - randomized self-checking bench for alu_op_seq
module tb_alu_op_seq;

  localparam int DW = 8;
  localparam int OW = 4;
  localparam int NO = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_opcode;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_chain;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [OW-1:0] sel;
  logic          enable;
  logic [DW-1:0] mux_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic          res_zero;
  logic          res_neg;
  logic          res_err;
  logic [7:0]    op_count;

  int checks = 0;
  int errors = 0;

  int            m_count;
  logic [DW-1:0] m_last;

  always #5 clk = ~clk;

  alu_op_seq #(
    .DATA_W  (DW),
    .OP_W    (OW),
    .NUM_OPS (NO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_chain  (in_chain),
    .op_a      (op_a),
    .op_b      (op_b),
    .sel       (sel),
    .enable    (enable),
    .mux_out   (mux_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_neg   (res_neg),
    .res_err   (res_err),
    .op_count  (op_count)
  );

  function automatic logic [DW-1:0] alu_ref(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << b[2:0];
      3:  return a >> b[2:0];
      4:  return (a == b) ? 8'h00 : ((a < b) ? 8'hFF : 8'h01);
      5:  return a & b;
      6:  return a | b;
      7:  return a ^ b;
      8:  return ~(a & b);
      9:  return ~(a | b);
      10: return ~(a ^ b);
      11: return ~a;
      12: return -a;
      default: return 8'h00;
    endcase
  endfunction

  // Outside ISSUE the mux returns junk so a capture at the wrong time shows up.
  assign mux_out = enable ? alu_ref(int'(sel), op_a, op_b) : (op_a ^ op_b ^ 8'h5A);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit chain, input int hold);
    logic [DW-1:0] ea;
    logic [DW-1:0] er;
    bit            legal;
    int            n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'd1);
    legal = (op < NO);
    ea    = chain ? m_last : a;
    er    = legal ? alu_ref(op, ea, b) : 8'h00;
    m_count = (m_count + 1) % 256;
    in_valid  = 1'b1;
    in_opcode = op[OW-1:0];
    in_a      = a;
    in_b      = b;
    in_chain  = chain;
    @(negedge clk);
    in_valid = 1'b0;
    chk("sel", 32'(sel), 32'(op));
    chk("op_a", 32'(op_a), 32'(ea));
    chk("op_b", 32'(op_b), 32'(b));
    chk("count", 32'(op_count), 32'(m_count));
    chk("ready_busy", 32'(in_ready), 32'd0);
    if (legal) begin
      chk("enable_issue", 32'(enable), 32'd1);
      chk("valid_issue", 32'(res_valid), 32'd0);
      @(negedge clk);
      m_last = er;
    end
    chk("enable_hold", 32'(enable), 32'd0);
    chk("valid_hold", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(er));
    chk("res_err", 32'(res_err), 32'(!legal));
    chk("res_zero", 32'(res_zero), 32'(er == 8'h00));
    chk("res_neg", 32'(res_neg), 32'(er[DW-1]));
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_opcode = OW'($urandom_range(0, 15));
      in_a      = DW'($urandom);
      in_b      = DW'($urandom);
      @(negedge clk);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_data", 32'(res_data), 32'(er));
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_enable", 32'(enable), 32'd0);
      chk("bp_count", 32'(op_count), 32'(m_count));
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("release_valid", 32'(res_valid), 32'd0);
    chk("release_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_b      = '0;
    in_chain  = 1'b0;
    res_ready = 1'b0;
    m_count   = 0;
    m_last    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_err", 32'(res_err), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);

    do_op(0, 8'h05, 8'h03, 1'b0, 0);
    chk("add_result", 32'(res_data), 32'h08);
    do_op(13, 8'h22, 8'h33, 1'b0, 2);
    do_op(0, 8'h44, 8'h01, 1'b0, 5);
    do_op(0, 8'h7F, 8'h01, 1'b0, 1);
    do_op(7, 8'h11, 8'h0F, 1'b1, 0);
    do_op(15, 8'h00, 8'h00, 1'b1, 0);
    do_op(6, 8'h00, 8'h00, 1'b1, 0);

    for (int k = 0; k < 150; k++)
      do_op(int'($urandom_range(0, 15)), DW'($urandom), DW'($urandom),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));

    // reset lands while the op is in ISSUE
    in_valid  = 1'b1;
    in_opcode = 4'd1;
    in_a      = 8'h90;
    in_b      = 8'h10;
    in_chain  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_enable", 32'(enable), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_count = 0;
    m_last  = '0;
    chk("mid_rst_enable", 32'(enable), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    @(negedge clk);
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    do_op(0, 8'h00, 8'h03, 1'b1, 0);

    for (int k = 0; k < 255; k++)
      do_op(int'($urandom_range(0, 15)), DW'($urandom), DW'($urandom),
            ($urandom_range(0, 1) == 1), 0);
    chk("wrap_count", 32'(op_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_seq.md
ALU_OP_SEQ -- requirements
Module: alu_op_seq

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width in bits.
REQ-002 Parameter OP_W, default 4, opcode width; drives sel.
REQ-003 Parameter NUM_OPS, default 13, count of legal opcodes (0..NUM_OPS-1).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  request present.
REQ-008 in_ready  output  1  block can accept a request.
REQ-009 in_opcode  input  OP_W  operation code: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 CMP, 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, 10 XNOR, 11 INV, 12 NEG.
REQ-010 in_a, in_b  input  DATA_W  operands.
REQ-011 in_chain  input  1  use last result in place of in_a.
REQ-012 op_a, op_b  output  DATA_W  registered operands to the operation units.
REQ-013 sel  output  OP_W  result-mux select.
REQ-014 enable  output  1  result-mux enable.
REQ-015 mux_out  input  DATA_W  selected result returned from the result mux (combinational path).
REQ-016 res_valid  output  1  result present.
REQ-017 res_ready  input  1  consumer accepts result.
REQ-018 res_data  output  DATA_W  captured result.
REQ-019 res_zero, res_neg  output  1  res_data==0; res_data[DATA_W-1].
REQ-020 res_err  output  1  opcode was illegal (>= NUM_OPS).
REQ-021 op_count  output  8  accepted-request counter.

Function
REQ-022 FSM states IDLE, ISSUE, HOLD; in_ready SHALL be 1 only in IDLE, decoded from registered state.
REQ-023 IDLE: on in_valid=1, capture opcode into sel, in_b into op_b, op_a <= (in_chain ? last_res : in_a); increment op_count; go ISSUE if opcode legal, else HOLD.
REQ-024 ISSUE lasts exactly one cycle with enable=1; at its closing edge res_data <= mux_out, res_err <= 0, last_res <= mux_out; go HOLD.
REQ-025 Illegal opcode: enable SHALL stay 0; res_data <= 0, res_err <= 1, last_res unchanged; go HOLD.
REQ-026 enable SHALL be 0 in IDLE and HOLD.
REQ-027 HOLD: res_valid=1; res_data, flags, res_err stable until res_ready=1, then IDLE next cycle.
REQ-028 Latency legal op: accept edge t -> res_valid high after edge t+1; illegal: after edge t.
REQ-029 Max throughput one op per 3 cycles; no request overlap; in_valid outside IDLE ignored.
REQ-030 op_count wraps 255 -> 0; counts legal and illegal requests.
REQ-031 res_zero/res_neg SHALL be derived combinationally from res_data.

Reset
REQ-032 reset SHALL dominate all inputs, including mid-ISSUE or mid-HOLD; in-flight op dropped.
REQ-033 Reset values: state IDLE, in_ready 1 (IDLE), enable 0, sel 0, op_a/op_b 0, res_valid 0, res_data 0, res_err 0, last_res 0, op_count 0.

Structure
REQ-034 Package alu_pkg SHALL hold opcode localparams, NUM_OPS, and the FSM state enum.
REQ-035 One sub-module alu_flag_gen (combinational zero/negative from res_data).

Verification
REQ-036 ADD: opcode 0, a=0x05, b=0x03, mux_out driven 0x08 -> enable high one cycle with sel=0, res_data 0x08, zero 0, neg 0, err 0.
REQ-037 Illegal: opcode 0xD -> enable never high, res_data 0x00, res_zero 1, res_err 1, op_count +1.
REQ-038 Backpressure: res_ready low 5 cycles -> res_valid and res_data held stable, in_ready 0, extra in_valid ignored.
REQ-039 Chain: first op result 0x80 (neg 1), then in_chain=1, in_a=0x11 -> op_a=0x80.
REQ-040 Reset asserted during ISSUE -> next cycle enable 0, res_valid 0, in_ready 1, op_count 0.
REQ-041 256 accepted ops -> op_count returns to 0x00.
